// File: rtl/grf_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard_pkg
// Description : Shared timing constants and operand-timing encodings for the
//               GPR hazard scoreboard and the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_scoreboard_pkg;

    // Default widths and MDU latencies
    localparam int GRF_TNEW_W  = 3;
    localparam int GRF_MD_W    = 4;
    localparam int GRF_MUL_LAT = 5;
    localparam int GRF_DIV_LAT = 10;

    // Tuse: cycles after D before the operand is consumed
    localparam logic [1:0] TUSE_D = 2'd0;   // branches, jr
    localparam logic [1:0] TUSE_E = 2'd1;   // ALU operands, addresses
    localparam logic [1:0] TUSE_M = 2'd2;   // store data

    // Tnew: cycles from E until the result can be forwarded
    localparam logic [GRF_TNEW_W-1:0] TNEW_NONE = 3'd0;
    localparam logic [GRF_TNEW_W-1:0] TNEW_ALU  = 3'd1;
    localparam logic [GRF_TNEW_W-1:0] TNEW_LOAD = 3'd2;
    localparam logic [GRF_TNEW_W-1:0] TNEW_MF   = 3'd1;

    // Instruction classes as seen by the decoder
    typedef enum logic [2:0] {
        IC_ALU    = 3'd0,
        IC_LOAD   = 3'd1,
        IC_STORE  = 3'd2,
        IC_BRANCH = 3'd3,
        IC_JR     = 3'd4,
        IC_MF     = 3'd5,
        IC_MD     = 3'd6
    } iclass_e;

    typedef struct packed {
        logic [1:0]            tuse_rs;
        logic [1:0]            tuse_rt;
        logic [GRF_TNEW_W-1:0] tnew;
    } op_timing_t;

    // Operand timing for each instruction class
    function automatic op_timing_t class_timing(input iclass_e ic);
        op_timing_t t;
        t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_E, tnew: TNEW_ALU};
        case (ic)
            IC_LOAD:   t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_E, tnew: TNEW_LOAD};
            IC_STORE:  t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_M, tnew: TNEW_NONE};
            IC_BRANCH: t = '{tuse_rs: TUSE_D, tuse_rt: TUSE_D, tnew: TNEW_NONE};
            IC_JR:     t = '{tuse_rs: TUSE_D, tuse_rt: TUSE_D, tnew: TNEW_NONE};
            IC_MF:     t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_E, tnew: TNEW_MF};
            IC_MD:     t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_E, tnew: TNEW_NONE};
            default:   t = '{tuse_rs: TUSE_E, tuse_rt: TUSE_E, tnew: TNEW_ALU};
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grf_scoreboard_sb_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_down_counter
// Description : Loadable down counter that saturates at zero, with a
//               nonzero flag. One per GPR and one for the MDU busy window.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_down_counter
    import grf_scoreboard_pkg::*;
#(
    parameter int W = GRF_TNEW_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_nz
);

    logic [W-1:0] r_count;

    // Load takes priority over the decrement; idle at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_nz    = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard
// Description : D-stage hazard controller for the 32x32 GPR file. Tracks per
//               register the cycles left until a result is forwardable, and
//               the multiply/divide unit busy window; stalls D when needed.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_scoreboard
    import grf_scoreboard_pkg::*;
#(
    parameter int TNEW_W  = GRF_TNEW_W,
    parameter int MUL_LAT = GRF_MUL_LAT,
    parameter int DIV_LAT = GRF_DIV_LAT,
    parameter int MD_W    = GRF_MD_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [1:0]        id_tuse_rs,
    input  logic [1:0]        id_tuse_rt,
    input  logic [4:0]        id_dst,
    input  logic [TNEW_W-1:0] id_tnew,
    input  logic              id_md_use,
    input  logic              id_md_start,
    input  logic              id_md_div,
    output logic              stall,
    output logic              issue,
    output logic [31:0]       busy_vec,
    output logic              md_busy
);

    // Compare width wide enough for both the count and the 2-bit tuse
    localparam int CMP_W = (TNEW_W > 2) ? TNEW_W : 2;

    // The extra cycle covers the D->E transit of the start instruction
    localparam logic [MD_W-1:0] C_MUL_LOAD = MD_W'(MUL_LAT + 1);
    localparam logic [MD_W-1:0] C_DIV_LOAD = MD_W'(DIV_LAT + 1);

    logic [31:0][TNEW_W-1:0] w_cnt;
    logic [TNEW_W-1:0]       w_cnt_rs;
    logic [TNEW_W-1:0]       w_cnt_rt;
    logic                    w_hz_rs;
    logic                    w_hz_rt;
    logic                    w_hz_md;
    logic [MD_W-1:0]         w_md_cnt;
    logic                    w_md_nz;
    logic                    w_md_load;
    logic [MD_W-1:0]         w_md_load_val;

    // r0 is hardwired: never busy, never loaded
    assign w_cnt[0]    = '0;
    assign busy_vec[0] = 1'b0;

    generate
        for (genvar r = 1; r < 32; r++) begin : g_gpr
            logic w_load;
            // Newest issued producer overwrites any older pending count
            assign w_load = issue && (id_dst == 5'(r));

            sb_down_counter #(
                .W (TNEW_W)
            ) u_cnt (
                .clk        (clk),
                .rst_n      (reset),
                .i_load     (w_load),
                .i_load_val (id_tnew),
                .o_count    (w_cnt[r]),
                .o_nz       (busy_vec[r])
            );
        end
    endgenerate

    assign w_md_load     = issue && id_md_start;
    assign w_md_load_val = id_md_div ? C_DIV_LOAD : C_MUL_LOAD;

    sb_down_counter #(
        .W (MD_W)
    ) u_md_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_md_load),
        .i_load_val (w_md_load_val),
        .o_count    (w_md_cnt),
        .o_nz       (w_md_nz)
    );

    // Hazards use the count before any load this cycle, so an instruction
    // that reads and writes the same register sees the older producer
    assign w_cnt_rs = w_cnt[id_rs];
    assign w_cnt_rt = w_cnt[id_rt];

    assign w_hz_rs = id_use_rs && (id_rs != 5'd0) &&
                     (CMP_W'(w_cnt_rs) > CMP_W'(id_tuse_rs));
    assign w_hz_rt = id_use_rt && (id_rt != 5'd0) &&
                     (CMP_W'(w_cnt_rt) > CMP_W'(id_tuse_rt));
    assign w_hz_md = id_md_use && (w_md_cnt != '0);

    assign stall   = id_valid && (w_hz_rs || w_hz_rt || w_hz_md);
    assign issue   = id_valid && !stall;
    assign md_busy = w_md_nz;

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_scoreboard
// Description : Self-checking bench for grf_scoreboard. Expected stall/issue
//               pairs are queued as each instruction is driven and popped
//               when the DUT outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [1:0]  id_tuse_rs;
    logic [1:0]  id_tuse_rt;
    logic [4:0]  id_dst;
    logic [2:0]  id_tnew;
    logic        id_md_use;
    logic        id_md_start;
    logic        id_md_div;
    logic        stall;
    logic        issue;
    logic [31:0] busy_vec;
    logic        md_busy;

    int          errors;
    int          checks;
    logic [1:0]  exp_q[$];
    logic [1:0]  exp_v;
    logic [1:0]  got_v;

    grf_scoreboard dut (
        .clk         (clk),
        .reset       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_dst      (id_dst),
        .id_tnew     (id_tnew),
        .id_md_use   (id_md_use),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .stall       (stall),
        .issue       (issue),
        .busy_vec    (busy_vec),
        .md_busy     (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one D-stage instruction (stimulus only)
    task automatic drive(input logic v,
                         input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [2:0] tnew,
                         input logic mu, input logic ms, input logic md);
        id_valid    = v;
        id_rs       = rs;
        id_use_rs   = urs;
        id_tuse_rs  = trs;
        id_rt       = rt;
        id_use_rt   = urt;
        id_tuse_rt  = trt;
        id_dst      = dst;
        id_tnew     = tnew;
        id_md_use   = mu;
        id_md_start = ms;
        id_md_div   = md;
    endtask

    task automatic idle();
        drive(0, 0,0,0, 0,0,0, 0,0, 0,0,0);
    endtask

    // Let every counter run out (longest window is 11 cycles)
    task automatic drain();
        idle();
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Would-be hazards on every source, plus an MDU start, while held in reset
        drive(1, 8,1,0, 9,1,0, 8,2, 1,1,1);
        exp_q.push_back(2'b01);
        @(negedge clk);
        exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset stall/issue got=%b exp=%b", got_v, exp_v); end
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset busy_vec got=%h exp=%h", busy_vec, 32'h0); end
        @(posedge clk); #1;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset md_busy got=%b exp=0", md_busy); end
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset busy_vec_hold got=%h exp=%h", busy_vec, 32'h0); end
        idle();
    endtask

    task automatic test_lw_use();
        logic [2:0] busy8_exp [4];
        busy8_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       begin drive(1, 0,1,1, 0,0,0, 8,2, 0,0,0); exp_q.push_back(2'b01); end
                1:       begin drive(1, 8,1,1, 8,1,1, 9,1, 0,0,0); exp_q.push_back(2'b10); end
                2:       begin drive(1, 8,1,1, 8,1,1, 9,1, 0,0,0); exp_q.push_back(2'b01); end
                default: begin idle();                             exp_q.push_back(2'b00); end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL lw_use c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            checks++;
            if (busy_vec[8] !== busy8_exp[c][0]) begin errors++; $display("FAIL lw_use c%0d busy8 got=%b exp=%b", c, busy_vec[8], busy8_exp[c][0]); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_branch();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                drive(1, 0,1,1, 0,0,0, 8,2, 0,0,0); exp_q.push_back(2'b01);
            end else begin
                drive(1, 8,1,0, 0,1,0, 0,0, 0,0,0); exp_q.push_back((c < 3) ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL branch c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            @(posedge clk); #1;
            if (c == 3) idle();
        end
        drain();
    endtask

    task automatic test_r0();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(1, 0,1,1, 0,0,0, 0,1, 0,0,0);
            else        drive(1, 0,1,0, 0,1,0, 0,0, 0,0,0);
            exp_q.push_back(2'b01);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL r0 c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            checks++;
            if (busy_vec !== 32'h0) begin errors++; $display("FAIL r0 c%0d busy_vec got=%h exp=%h", c, busy_vec, 32'h0); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_mdu();
        int n_stall;
        // mult then mflo (6 stalls), div then mflo (11 stalls)
        for (int k = 0; k < 2; k++) begin
            n_stall = (k == 0) ? 6 : 11;
            drive(1, 4,1,1, 5,1,1, 0,0, 1,1,k[0]); exp_q.push_back(2'b01);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL mdu%0d start stall/issue got=%b exp=%b", k, got_v, exp_v); end
            @(posedge clk); #1;
            for (int c = 0; c <= n_stall; c++) begin
                drive(1, 0,0,0, 0,0,0, 2,1, 1,0,0);
                exp_q.push_back((c < n_stall) ? 2'b10 : 2'b01);
                @(negedge clk);
                exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
                if (got_v !== exp_v) begin errors++; $display("FAIL mdu%0d mflo c%0d stall/issue got=%b exp=%b", k, c, got_v, exp_v); end
                if (c == 0) begin
                    checks++;
                    if (md_busy !== 1'b1) begin errors++; $display("FAIL mdu%0d md_busy got=%b exp=1", k, md_busy); end
                end
                @(posedge clk); #1;
            end
            drain();
        end
        // mult, unrelated add issues freely, mflo then waits the remaining 5
        drive(1, 0,0,0, 0,0,0, 0,0, 1,1,0); exp_q.push_back(2'b01);
        @(negedge clk);
        exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL mdu_mix start stall/issue got=%b exp=%b", got_v, exp_v); end
        @(posedge clk); #1;
        drive(1, 3,1,1, 4,1,1, 6,1, 0,0,0); exp_q.push_back(2'b01);
        @(negedge clk);
        exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL mdu_mix add stall/issue got=%b exp=%b", got_v, exp_v); end
        @(posedge clk); #1;
        for (int c = 0; c <= 5; c++) begin
            drive(1, 0,0,0, 0,0,0, 2,1, 1,0,0);
            exp_q.push_back((c < 5) ? 2'b10 : 2'b01);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL mdu_mix mflo c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_waw();
        logic [1:0] e [5];
        e = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       drive(1, 0,1,1, 0,0,0, 5,2, 0,0,0);  // lw $5
                1, 2:    drive(1, 5,1,1, 0,0,0, 5,1, 0,0,0);  // addi $5,$5
                default: drive(1, 5,1,0, 0,1,0, 0,0, 0,0,0);  // beq $5,$0
            endcase
            exp_q.push_back(e[c]);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL waw c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_rt_and_gating();
        logic [1:0] e [7];
        e = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: drive(1, 0,1,1, 0,0,0, 4,2, 0,0,0);        // lw $4
                1: drive(0, 4,1,0, 4,1,0, 0,0, 1,0,0);        // invalid slot with hazards
                2: drive(1, 4,0,0, 4,1,1, 0,0, 0,0,0);        // rs unused, rt tuse1, cnt=1
                3: drive(1, 0,1,1, 0,0,0, 6,2, 0,0,0);        // lw $6
                4: drive(1, 0,1,1, 6,1,1, 9,1, 0,0,0);        // add rt=$6: stall
                5: drive(1, 0,1,1, 6,1,1, 9,1, 0,0,0);        // add rt=$6: issue
                default: drive(1, 9,0,0, 9,1,2, 0,0, 0,0,0);  // sw rt=$9 tuse2 vs cnt=1
            endcase
            exp_q.push_back(e[c]);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL rt_gate c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            @(posedge clk); #1;
        end
        // lw $7 immediately followed by sw rt=$7 (cnt 2, tuse 2): no stall
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(1, 0,1,1, 0,0,0, 7,2, 0,0,0);
            else        drive(1, 0,1,1, 7,1,2, 0,0, 0,0,0);
            exp_q.push_back(2'b01);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL sw_bound c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [1:0] e [4];
        e = '{2'b01, 2'b01, 2'b10, 2'b10};
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       drive(1, 0,0,0, 0,0,0, 0,0, 1,1,1);  // div
                1:       drive(1, 0,1,1, 0,0,0, 3,2, 0,0,0);  // lw $3
                default: drive(1, 0,0,0, 0,0,0, 2,1, 1,0,0);  // mflo
            endcase
            exp_q.push_back(e[c]);
            @(negedge clk);
            exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL rst_mid c%0d stall/issue got=%b exp=%b", c, got_v, exp_v); end
            if (c < 3) begin @(posedge clk); #1; end
        end
        checks++;
        if ({md_busy, busy_vec[3]} !== 2'b11) begin errors++; $display("FAIL rst_mid pre md_busy/busy3 got=%b exp=11", {md_busy, busy_vec[3]}); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, md_busy} !== 2'b00) begin errors++; $display("FAIL rst_mid async stall/md_busy got=%b exp=00", {stall, md_busy}); end
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL rst_mid async busy_vec got=%h exp=%h", busy_vec, 32'h0); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(2'b01);
        @(negedge clk);
        exp_v = exp_q.pop_front(); got_v = {stall, issue}; checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL rst_mid after mflo stall/issue got=%b exp=%b", got_v, exp_v); end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_lw_use();
        test_branch();
        test_r0();
        test_mdu();
        test_waw();
        test_rt_and_gating();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/grf_scoreboard.md
# grf_scoreboard

Issue-stage hazard controller for the 32×32 general register file in the 5-stage MIPS pipeline. It tracks, per GPR, how many cycles remain until an in-flight result can be forwarded, and stalls the D-stage instruction when a source operand is not ready in time. It also sequences access to the multiply/divide unit by tracking its busy window.

## Interface
Parameters:
- TNEW_W, 3, width of per-register ready countdown and of id_tnew
- MUL_LAT, 5, multiply busy cycles after start
- DIV_LAT, 10, divide busy cycles after start
- MD_W, 4, width of MDU busy counter (must hold DIV_LAT+1)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low (0 = reset)
- id_valid  in  1  D stage holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_tuse_rs, id_tuse_rt  in  2 each  cycles after D until operand needed (0 = D, 1 = E)
- id_dst  in  5  destination GPR (0 = none)
- id_tnew  in  TNEW_W  cycles until result forwardable, counted from the cycle the instruction is in E
- id_md_use  in  1  instruction touches HI/LO/MDU (mult/div/mf*/mt*)
- id_md_start  in  1  instruction is mult/multu/div/divu
- id_md_div  in  1  1 = divide, 0 = multiply (valid with id_md_start)
- stall  out  1  freeze PC/D, bubble into E
- issue  out  1  id_valid & ~stall
- busy_vec  out  32  bit r = cnt[r] != 0
- md_busy  out  1  MDU counter nonzero

## Operation
- Per register r in 1..31: counter cnt[r] (TNEW_W). cnt[0] constant 0; writes to r0 are ignored.
- Hazard rs: id_use_rs & id_rs != 0 & cnt[id_rs] > id_tuse_rs (unsigned compare, tuse zero-extended). Same for rt.
- Hazard md: id_md_use & md_cnt != 0.
- stall = id_valid & (hazard_rs | hazard_rt | hazard_md). stall is 0 when id_valid = 0.
- Each cycle every nonzero cnt[r] decrements by 1; saturates at 0.
- On issue with id_dst != 0: cnt[id_dst] <= id_tnew (overrides decrement; WAW resolves to newest producer).
- Issue whose id_dst is also its own source: hazard is evaluated on the old count before the load.
- md_cnt: decrements to 0. On issue & id_md_start: md_cnt <= (id_md_div ? DIV_LAT : MUL_LAT) + 1 (one extra cycle covers D->E transit).
- Stalled cycles still decrement all counters.

## Timing
- stall, issue, hazards: combinational from current state and same-cycle inputs.
- Counter updates on posedge clk; a load is visible the following cycle.
- Reset (asynchronous assert, synchronous-deassert handled upstream): all cnt = 0, md_cnt = 0, busy_vec = 0, md_busy = 0; stall = 0 for any input while counters are 0 and id_md_use is 0.
- Reset mid-stall clears all state immediately; next cycle's instruction issues unless new hazards arise.
- Standard values: ALU tnew=1, lw tnew=2, mfhi/mflo tnew=1; ALU tuse=1, beq/jr tuse=0, sw rt tuse=2.

## Structure
- Shared package: TNEW_W, MD_W, MUL_LAT, DIV_LAT, tuse/tnew encodings per instruction class (consumed also by the decoder).
- One sub-module sb_down_counter (load, saturating decrement, nonzero flag), instantiated for 31 GPRs and once for MDU with width MD_W.

## Test plan
- lw $8 issued (tnew=2), next cycle add $9,$8,$8 (tuse=1) -> stall=1 one cycle, issue on second cycle; busy_vec[8] 1 then 0.
- lw $8, next beq $8,$0 (tuse=0) -> stall two cycles, issue third.
- addi $0 (dst=0, tnew=1), next uses $0 tuse=0 -> no stall; busy_vec = 0.
- mult issued, next cycle mflo -> md_busy=1, stall exactly 6 cycles; div -> 11 cycles; non-MD add during window issues with no stall.
- lw $5 (tnew=2) then immediately addi $5 (tnew=1) issued after one stall -> cnt[5] reloaded to 1, newer consumer waits per newer tnew.
- Assert reset=0 during a div stall -> md_busy, busy_vec, stall drop to 0 asynchronously; after release, mflo issues immediately.
